// File: rtl/npu_arb_pkg.sv
// Shared types and defaults for the NPU host arbiter.
// The per-requester count slice helper keeps the bus-slicing arithmetic in one place.
package npu_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 2;
    localparam int unsigned CNT_W_DEFAULT   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDone
    } arb_state_e;

    function automatic int unsigned cnt_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/npu_rr_picker.sv
// Combinational round-robin select: first asserted request at or after rr_ptr, with wrap.
module npu_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               pick_valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(rr_ptr) + off) % NUM_REQ);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick[idx]  = 1'b1;
                pick_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/npu_host_arbiter.sv
// Shares one NPU between NUM_REQ host requesters, one complete invocation at a time.
// Ownership is round-robin; release happens once the latched input and output counts drain.
module npu_host_arbiter
    import npu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] in_cnt,
    input  logic [NUM_REQ*CNT_W-1:0] out_cnt,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    input  logic [NUM_REQ*32-1:0]    req_in_data,
    input  logic [NUM_REQ-1:0]       req_in_valid,
    output logic [NUM_REQ-1:0]       req_in_ready,
    output logic [31:0]              req_out_data,
    output logic [NUM_REQ-1:0]       req_out_valid,
    input  logic [NUM_REQ-1:0]       req_out_ready,
    output logic [31:0]              npu_input_data,
    output logic                     npu_input_fifo_write_enable,
    input  logic                     npu_input_fifo_full,
    output logic                     npu_output_fifo_read_enable,
    input  logic [31:0]              npu_output_data,
    input  logic                     npu_output_fifo_empty
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   in_rem_q;
    logic [CNT_W-1:0]   out_rem_q;
    logic [CNT_W-1:0]   in_rem_d;
    logic [CNT_W-1:0]   out_rem_d;

    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [CNT_W-1:0]   pick_in_cnt;
    logic [CNT_W-1:0]   pick_out_cnt;

    logic               owned;
    logic               in_ok;
    logic               out_ok;
    logic               wr_en;
    logic               rd_en;

    npu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // Counts are taken from whichever requester wins this cycle's arbitration.
    always_comb begin
        pick_in_cnt  = '0;
        pick_out_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_in_cnt  = in_cnt[cnt_lsb(i, CNT_W) +: CNT_W];
                pick_out_cnt = out_cnt[cnt_lsb(i, CNT_W) +: CNT_W];
            end
        end
    end

    // grant_q is only nonzero in XFER, so it gates every owner-side handshake.
    always_comb begin
        owned         = |grant_q;
        in_ok         = owned && !npu_input_fifo_full && (in_rem_q != '0);
        out_ok        = owned && !npu_output_fifo_empty && (out_rem_q != '0);
        req_in_ready  = in_ok ? grant_q : '0;
        req_out_valid = out_ok ? grant_q : '0;
        wr_en         = |(req_in_valid & req_in_ready);
        rd_en         = |(req_out_ready & req_out_valid);
        in_rem_d      = in_rem_q - CNT_W'(wr_en);
        out_rem_d     = out_rem_q - CNT_W'(rd_en);
        next_ptr      = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        npu_input_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                npu_input_data = req_in_data[cnt_lsb(i, 32) +: 32];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            done_q    <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            in_rem_q  <= '0;
            out_rem_q <= '0;
        end else begin
            done_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_q   <= pick;
                        owner_q   <= pick_idx;
                        in_rem_q  <= pick_in_cnt;
                        out_rem_q <= pick_out_cnt;
                        state_q   <= StXfer;
                    end
                end
                StXfer: begin
                    in_rem_q  <= in_rem_d;
                    out_rem_q <= out_rem_d;
                    if (in_rem_d == '0 && out_rem_d == '0) begin
                        grant_q  <= '0;
                        done_q   <= grant_q;
                        rr_ptr_q <= next_ptr;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant                       = grant_q;
    assign done                        = done_q;
    assign req_out_data                = npu_output_data;
    assign npu_input_fifo_write_enable = wr_en;
    assign npu_output_fifo_read_enable = rd_en;

endmodule

// File: tb/tb_npu_host_arbiter.sv
// Directed bench for npu_host_arbiter with two requesters and 8-bit counts.
module tb_npu_host_arbiter;

    logic        CLK;
    logic        RST;
    logic [1:0]  req;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [63:0] req_in_data;
    logic [1:0]  req_in_valid;
    logic [1:0]  req_in_ready;
    logic [31:0] req_out_data;
    logic [1:0]  req_out_valid;
    logic [1:0]  req_out_ready;
    logic [31:0] npu_input_data;
    logic        npu_input_fifo_write_enable;
    logic        npu_input_fifo_full;
    logic        npu_output_fifo_read_enable;
    logic [31:0] npu_output_data;
    logic        npu_output_fifo_empty;

    int n_pass;
    int n_total;

    npu_host_arbiter #(
        .NUM_REQ (2),
        .CNT_W   (8)
    ) dut (
        .CLK                         (CLK),
        .RST                         (RST),
        .req                         (req),
        .in_cnt                      (in_cnt),
        .out_cnt                     (out_cnt),
        .grant                       (grant),
        .done                        (done),
        .req_in_data                 (req_in_data),
        .req_in_valid                (req_in_valid),
        .req_in_ready                (req_in_ready),
        .req_out_data                (req_out_data),
        .req_out_valid               (req_out_valid),
        .req_out_ready               (req_out_ready),
        .npu_input_data              (npu_input_data),
        .npu_input_fifo_write_enable (npu_input_fifo_write_enable),
        .npu_input_fifo_full         (npu_input_fifo_full),
        .npu_output_fifo_read_enable (npu_output_fifo_read_enable),
        .npu_output_data             (npu_output_data),
        .npu_output_fifo_empty       (npu_output_fifo_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req                   = '0;
        in_cnt                = '0;
        out_cnt               = '0;
        req_in_data           = '0;
        req_in_valid          = '0;
        req_out_ready         = '0;
        npu_input_fifo_full   = 1'b0;
        npu_output_data       = '0;
        npu_output_fifo_empty = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
        n_total++; if (done !== 2'b00) $display("FAIL reset_done: got %b want 00", done); else n_pass++;
        n_total++; if ({req_in_ready, req_out_valid} !== 4'b0) $display("FAIL reset_handshake: got %b want 0000", {req_in_ready, req_out_valid}); else n_pass++;
        n_total++; if ({npu_input_fifo_write_enable, npu_output_fifo_read_enable} !== 2'b00) $display("FAIL reset_fifo_en: got %b want 00", {npu_input_fifo_write_enable, npu_output_fifo_read_enable}); else n_pass++;
        RST = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_cnt[7:0]     = 8'd3;
        out_cnt[7:0]    = 8'd1;
        req_in_data[31:0] = 32'h100;
        req_in_valid    = 2'b01;
        req             = 2'b01;
        #1;
        n_total++; if (grant !== 2'b00) $display("FAIL single_grant_early: got %b want 00", grant); else n_pass++;
        tick();
        n_total++; if (grant !== 2'b01) $display("FAIL single_grant: got %b want 01", grant); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            req_in_data[31:0] = 32'h100 + 32'(c);
            #1;
            n_total++; if (npu_input_fifo_write_enable !== 1'b1) $display("FAIL single_wr_en[%0d]: got %b want 1", c, npu_input_fifo_write_enable); else n_pass++;
            n_total++; if (npu_input_data !== 32'h100 + 32'(c)) $display("FAIL single_wr_data[%0d]: got %h want %h", c, npu_input_data, 32'h100 + 32'(c)); else n_pass++;
            tick();
        end
        n_total++; if ({npu_input_fifo_write_enable, req_in_ready} !== 3'b000) $display("FAIL single_in_drained: got %b want 000", {npu_input_fifo_write_enable, req_in_ready}); else n_pass++;
        n_total++; if ({grant, done} !== 4'b0100) $display("FAIL single_wait_out: got %b want 0100", {grant, done}); else n_pass++;
        npu_output_data       = 32'hDEADBEEF;
        npu_output_fifo_empty = 1'b0;
        req_out_ready         = 2'b01;
        #1;
        n_total++; if (req_out_valid !== 2'b01) $display("FAIL single_out_valid: got %b want 01", req_out_valid); else n_pass++;
        n_total++; if (npu_output_fifo_read_enable !== 1'b1) $display("FAIL single_rd_en: got %b want 1", npu_output_fifo_read_enable); else n_pass++;
        n_total++; if (req_out_data !== 32'hDEADBEEF) $display("FAIL single_out_data: got %h want deadbeef", req_out_data); else n_pass++;
        tick();
        n_total++; if ({grant, done} !== 4'b0001) $display("FAIL single_done: got %b want 0001", {grant, done}); else n_pass++;
        n_total++; if (npu_output_fifo_read_enable !== 1'b0) $display("FAIL single_no_extra_pop: got %b want 0", npu_output_fifo_read_enable); else n_pass++;
        idle_inputs();
        tick();
        n_total++; if ({grant, done} !== 4'b0000) $display("FAIL single_after_done: got %b want 0000", {grant, done}); else n_pass++;
    endtask

    task automatic test_round_robin();
        RST = 1'b0;
        #1;
        tick();
        in_cnt                = {8'd1, 8'd1};
        out_cnt               = {8'd1, 8'd1};
        req_in_valid          = 2'b11;
        req_out_ready         = 2'b11;
        npu_output_fifo_empty = 1'b0;
        npu_output_data       = 32'h55;
        req                   = 2'b11;
        RST                   = 1'b1;
        tick();
        n_total++; if (grant !== 2'b01) $display("FAIL rr_first: got %b want 01", grant); else n_pass++;
        n_total++; if ({req_in_ready, req_out_valid} !== 4'b0101) $display("FAIL rr_nonowner: got %b want 0101", {req_in_ready, req_out_valid}); else n_pass++;
        tick();
        n_total++; if ({grant, done} !== 4'b0001) $display("FAIL rr_done0: got %b want 0001", {grant, done}); else n_pass++;
        tick();
        n_total++; if (grant !== 2'b00) $display("FAIL rr_gap: got %b want 00", grant); else n_pass++;
        tick();
        n_total++; if (grant !== 2'b10) $display("FAIL rr_second: got %b want 10", grant); else n_pass++;
        tick();
        n_total++; if ({grant, done} !== 4'b0010) $display("FAIL rr_done1: got %b want 0010", {grant, done}); else n_pass++;
        tick();
        tick();
        n_total++; if (grant !== 2'b01) $display("FAIL rr_third: got %b want 01", grant); else n_pass++;
        req = 2'b00;
        tick();
        n_total++; if (done !== 2'b01) $display("FAIL rr_done0b: got %b want 01", done); else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_full_stall();
        logic [7:0] fulls;
        int rem;
        int obs;
        fulls = 8'b0001_1110;
        rem   = 4;
        obs   = 0;
        in_cnt[15:8] = 8'd4;
        req_in_valid = 2'b10;
        req          = 2'b10;
        tick();
        n_total++; if (grant !== 2'b10) $display("FAIL stall_grant: got %b want 10", grant); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            logic exp_wr;
            npu_input_fifo_full = fulls[c];
            req_in_data[63:32]  = 32'h200 + 32'(obs);
            #1;
            exp_wr = !fulls[c] && (rem != 0);
            n_total++; if ({npu_input_fifo_write_enable, req_in_ready} !== {exp_wr, exp_wr, 1'b0}) $display("FAIL stall_wr[%0d]: got %b want %b", c, {npu_input_fifo_write_enable, req_in_ready}, {exp_wr, exp_wr, 1'b0}); else n_pass++;
            if (exp_wr) begin
                rem--;
                n_total++; if (npu_input_data !== 32'h200 + 32'(obs)) $display("FAIL stall_data[%0d]: got %h want %h", c, npu_input_data, 32'h200 + 32'(obs)); else n_pass++;
            end
            if (npu_input_fifo_write_enable === 1'b1) obs++;
            tick();
        end
        n_total++; if (obs !== 4) $display("FAIL stall_write_count: got %0d want 4", obs); else n_pass++;
        n_total++; if ({grant, done} !== 4'b0010) $display("FAIL stall_done: got %b want 0010", {grant, done}); else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_zero_count();
        req_in_valid          = 2'b01;
        req_out_ready         = 2'b01;
        npu_output_fifo_empty = 1'b0;
        req                   = 2'b01;
        tick();
        n_total++; if (grant !== 2'b01) $display("FAIL zero_grant: got %b want 01", grant); else n_pass++;
        n_total++; if ({npu_input_fifo_write_enable, npu_output_fifo_read_enable} !== 2'b00) $display("FAIL zero_fifo: got %b want 00", {npu_input_fifo_write_enable, npu_output_fifo_read_enable}); else n_pass++;
        req = 2'b00;
        tick();
        n_total++; if ({grant, done} !== 4'b0001) $display("FAIL zero_done: got %b want 0001", {grant, done}); else n_pass++;
        tick();
        n_total++; if (done !== 2'b00) $display("FAIL zero_done_pulse: got %b want 00", done); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_drop_req();
        in_cnt[15:8] = 8'd1;
        req          = 2'b10;
        tick();
        n_total++; if (grant !== 2'b10) $display("FAIL drop_grant: got %b want 10", grant); else n_pass++;
        req = 2'b00;
        tick();
        n_total++; if (grant !== 2'b10) $display("FAIL drop_hold: got %b want 10", grant); else n_pass++;
        req_in_valid = 2'b10;
        #1;
        n_total++; if (npu_input_fifo_write_enable !== 1'b1) $display("FAIL drop_wr: got %b want 1", npu_input_fifo_write_enable); else n_pass++;
        tick();
        n_total++; if ({grant, done} !== 4'b0010) $display("FAIL drop_done: got %b want 0010", {grant, done}); else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        // Zero-count pass on requester 0 moves the pointer to requester 1.
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tick();
        in_cnt[15:8]       = 8'd4;
        req_in_data[63:32] = 32'h300;
        req_in_valid       = 2'b10;
        req                = 2'b10;
        tick();
        n_total++; if (grant !== 2'b10) $display("FAIL rst_mid_grant: got %b want 10", grant); else n_pass++;
        tick();
        tick();
        RST = 1'b0;
        #1;
        n_total++; if ({grant, req_in_ready, npu_input_fifo_write_enable} !== 5'b0) $display("FAIL rst_mid_outputs: got %b want 00000", {grant, req_in_ready, npu_input_fifo_write_enable}); else n_pass++;
        tick();
        in_cnt       = {8'd1, 8'd1};
        req_in_valid = 2'b11;
        req          = 2'b11;
        RST          = 1'b1;
        tick();
        n_total++; if (grant !== 2'b01) $display("FAIL rst_mid_priority: got %b want 01", grant); else n_pass++;
        req = 2'b00;
        tick();
        n_total++; if (done !== 2'b01) $display("FAIL rst_mid_done: got %b want 01", done); else n_pass++;
        idle_inputs();
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_zero_count();
        test_drop_req();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/npu_host_arbiter.md
Name: npu_host_arbiter

Overview:
- Shares one NPU instance between NUM_REQ host requesters, one complete invocation at a time.
- Grants ownership round-robin and latches the owner's input-word and output-word counts.
- Steers the owner's input stream into the NPU input FIFO and returns NPU output FIFO words to the owner.
- Releases ownership once both counts are exhausted. Sits between the host cores and the NPU top level; the config port is not arbitrated.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CNT_W, 8, width of per-invocation input/output word counts.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  per-requester invocation request, level.
- in_cnt  in  NUM_REQ*CNT_W  words requester i will push; slice i = [i*CNT_W +: CNT_W].
- out_cnt  in  NUM_REQ*CNT_W  words requester i will pop.
- grant  out  NUM_REQ  one-hot owner indication, registered.
- done  out  NUM_REQ  one-cycle pulse when owner's invocation completes.
- req_in_data  in  NUM_REQ*32  per-requester input word.
- req_in_valid  in  NUM_REQ  input word valid.
- req_in_ready  out  NUM_REQ  input word accepted this cycle.
- req_out_data  out  32  NPU output word, broadcast to all requesters.
- req_out_valid  out  NUM_REQ  output word valid for the owner only.
- req_out_ready  in  NUM_REQ  owner consumes output word.
- npu_input_data  out  32  to NPU input FIFO.
- npu_input_fifo_write_enable  out  1  NPU input FIFO push.
- npu_input_fifo_full  in  1  NPU input FIFO full.
- npu_output_fifo_read_enable  out  1  NPU output FIFO pop.
- npu_output_data  in  32  NPU output FIFO head; first-word-fall-through, valid whenever not empty.
- npu_output_fifo_empty  in  1  NPU output FIFO empty.

Behaviour:
- Reset (RST low, asynchronous):
  - state=IDLE; grant=0; done=0; in_rem=0; out_rem=0.
  - rr_ptr=0, so requester 0 has highest priority.
  - All combinational outputs are 0 because grant=0.
- State IDLE:
  - If req!=0, pick the first asserted req searching from rr_ptr upward with wrap.
  - Next edge: grant[k]=1, in_rem<=in_cnt[k], out_rem<=out_cnt[k], state=XFER.
  - Grant latency from req rising: 1 cycle.
- State XFER, input side, all combinational on owner k:
  - req_in_ready[k] = !npu_input_fifo_full & in_rem!=0.
  - npu_input_fifo_write_enable = req_in_valid[k] & req_in_ready[k].
  - npu_input_data = req_in_data[k].
  - in_rem decrements on each write.
- State XFER, output side, all combinational on owner k:
  - req_out_valid[k] = !npu_output_fifo_empty & out_rem!=0.
  - npu_output_fifo_read_enable = req_out_valid[k] & req_out_ready[k].
  - req_out_data = npu_output_data at all times.
  - out_rem decrements on each read.
- Input and output transfers may both occur in the same cycle; they are independent.
- XFER -> DONE when in_rem==0 and out_rem==0, after counting the current cycle's transfers.
- A zero-count invocation (in_cnt=0, out_cnt=0) reaches DONE on the cycle after the grant.
- State DONE, one cycle:
  - done[k]=1, grant=0, rr_ptr=(k+1) mod NUM_REQ.
  - Next state IDLE. New arbitration occurs in IDLE, so owner changes have a 2-cycle gap.
- Non-owners always see req_in_ready=0 and req_out_valid=0.
- req deassertion during XFER is ignored; the invocation runs to completion, with no abort.
- in_cnt and out_cnt are sampled only at grant; later changes have no effect.
- Never write when full or read when empty, even if the owner's valid/ready is asserted.
- Extra NPU output words beyond out_cnt stay in the FIFO and are not popped.
- Counters never underflow; they decrement only when nonzero.

Decomposition:
- Package npu_arb_pkg: state encoding (IDLE, XFER, DONE), default NUM_REQ and CNT_W, and a function for the CNT_W slice index.
- Sub-module npu_rr_picker: combinational round-robin one-hot select from req and rr_ptr, instantiated once.

Test Plan:
- Single requester 0: in_cnt=3, out_cnt=1, valid held high, FIFO never full.
  - Required: grant[0] 1 cycle after req, exactly 3 write_enable pulses carrying the req_in_data values.
  - After empty deasserts with npu_output_data=0xDEADBEEF: one read, req_out_data=0xDEADBEEF, done[0] pulse, grant returns to 0.
- Both requesters asserted from reset, each with 1/1 counts.
  - Required: requester 0 served first, then requester 1, then requester 0 again if req is still high.
- npu_input_fifo_full=1 for 4 cycles mid-invocation with in_cnt=4.
  - Required: no write_enable and req_in_ready=0 during the stall; 4 writes total, no words lost or duplicated.
- in_cnt=0, out_cnt=0.
  - Required: grant for 1 cycle, done pulse on the next cycle, no FIFO activity.
- Owner drops req after the grant.
  - Required: the invocation completes normally and the done pulse is still issued.
- RST low mid-XFER with in_rem=2.
  - Required: outputs immediately 0, no write_enable; after release, requester 0 has priority again.
